// File: rtl/br_predict_if.sv
// Fetch/EX-side signal bundle of the branch-prediction controller.
// The pipeline side uses master, the controller uses slave.
interface br_predict_if #(
  parameter int STAT_W = 16
);
  logic              btb_hit;
  logic [31:0]       btb_pre_pc;
  logic              stall;
  logic [31:0]       ex_pc;
  logic              ex_is_br;
  logic              ex_taken;
  logic [31:0]       ex_target;
  logic [1:0]        btb_flush;
  logic [31:0]       upd_pc;
  logic [31:0]       upd_target;
  logic              redirect;
  logic [31:0]       redirect_pc;
  logic [STAT_W-1:0] br_cnt;
  logic [STAT_W-1:0] mis_cnt;

  modport master (
    output btb_hit,
    output btb_pre_pc,
    output stall,
    output ex_pc,
    output ex_is_br,
    output ex_taken,
    output ex_target,
    input  btb_flush,
    input  upd_pc,
    input  upd_target,
    input  redirect,
    input  redirect_pc,
    input  br_cnt,
    input  mis_cnt
  );

  modport slave (
    input  btb_hit,
    input  btb_pre_pc,
    input  stall,
    input  ex_pc,
    input  ex_is_br,
    input  ex_taken,
    input  ex_target,
    output btb_flush,
    output upd_pc,
    output upd_target,
    output redirect,
    output redirect_pc,
    output br_cnt,
    output mis_cnt
  );
endinterface

// File: rtl/br_predict_ctrl.sv
// BTB prediction tracker: carries fetch-time BTB results to EX, resolves
// them, drives BTB update/redirect/squash and keeps per-index hysteresis.
module br_predict_ctrl #(
  parameter int STAT_W = 16
) (
  input  logic         clk,
  input  logic         rst,
  br_predict_if.slave  bp
);

  typedef struct packed {
    logic        v;
    logic        hit;
    logic [31:0] pre_pc;
  } trk_t;

  localparam logic [1:0] FL_NONE = 2'b00;
  localparam logic [1:0] FL_INV  = 2'b01;
  localparam logic [1:0] FL_INST = 2'b10;

  trk_t              r_ifid;
  trk_t              r_idex;
  logic [15:0][1:0]  r_cnt;
  logic [STAT_W-1:0] r_br_cnt;
  logic [STAT_W-1:0] r_mis_cnt;

  logic              w_dec;
  logic [3:0]        w_idx;
  logic [1:0]        w_cnt;
  logic [31:0]       w_seq_pc;
  logic              w_tgt_ok;
  logic              w_a;
  logic              w_b;
  logic              w_c;
  logic              w_d;
  logic              w_f;
  logic [1:0]        w_flush;
  logic              w_redir;
  logic [31:0]       w_rpc;
  logic              w_cnt_we;
  logic [1:0]        w_cnt_nx;

  // A decision needs a live EX slot, an advancing pipe and no reset.
  assign w_dec    = rst && !bp.stall && r_idex.v;
  assign w_idx    = bp.ex_pc[5:2];
  assign w_cnt    = r_cnt[w_idx];
  assign w_seq_pc = bp.ex_pc + 32'd4;
  assign w_tgt_ok = (r_idex.pre_pc == bp.ex_target);

  assign w_a = bp.ex_is_br && bp.ex_taken && r_idex.hit && w_tgt_ok;
  assign w_b = bp.ex_is_br && bp.ex_taken && r_idex.hit && !w_tgt_ok;
  assign w_c = bp.ex_is_br && bp.ex_taken && !r_idex.hit;
  assign w_d = bp.ex_is_br && !bp.ex_taken && r_idex.hit;
  assign w_f = !bp.ex_is_br && r_idex.hit;

  always_comb begin
    w_flush  = FL_NONE;
    w_redir  = 1'b0;
    w_rpc    = 32'd0;
    w_cnt_we = 1'b0;
    w_cnt_nx = w_cnt;
    if (w_dec) begin
      unique case (1'b1)
        w_a: begin
          w_cnt_we = 1'b1;
          w_cnt_nx = (w_cnt == 2'b11) ? 2'b11 : w_cnt + 2'd1;
        end
        w_b, w_c: begin
          w_redir  = 1'b1;
          w_rpc    = bp.ex_target;
          w_flush  = FL_INST;
          w_cnt_we = 1'b1;
          w_cnt_nx = 2'b10;
        end
        w_d: begin
          w_redir  = 1'b1;
          w_rpc    = w_seq_pc;
          w_cnt_we = 1'b1;
          // Strong entries survive one not-taken outcome.
          if (w_cnt[1]) begin
            w_cnt_nx = w_cnt - 2'd1;
          end else begin
            w_flush  = FL_INV;
            w_cnt_nx = 2'b00;
          end
        end
        w_f: begin
          w_redir  = 1'b1;
          w_rpc    = w_seq_pc;
          w_flush  = FL_INV;
          w_cnt_we = 1'b1;
          w_cnt_nx = 2'b00;
        end
        default: begin
          w_cnt_we = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ifid <= '0;
      r_idex <= '0;
    end else if (!bp.stall) begin
      r_ifid.v      <= !w_redir;
      r_ifid.hit    <= bp.btb_hit;
      r_ifid.pre_pc <= bp.btb_pre_pc;
      r_idex.v      <= r_ifid.v && !w_redir;
      r_idex.hit    <= r_ifid.hit;
      r_idex.pre_pc <= r_ifid.pre_pc;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (w_cnt_we) begin
      r_cnt[w_idx] <= w_cnt_nx;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_br_cnt  <= '0;
      r_mis_cnt <= '0;
    end else begin
      if (w_dec && bp.ex_is_br && !(&r_br_cnt)) begin
        r_br_cnt <= r_br_cnt + 1'b1;
      end
      if (w_redir && !(&r_mis_cnt)) begin
        r_mis_cnt <= r_mis_cnt + 1'b1;
      end
    end
  end

  assign bp.btb_flush   = w_flush;
  assign bp.redirect    = w_redir;
  assign bp.redirect_pc = w_rpc;
  assign bp.upd_pc      = bp.ex_pc;
  assign bp.upd_target  = bp.ex_target;
  assign bp.br_cnt      = r_br_cnt;
  assign bp.mis_cnt     = r_mis_cnt;

endmodule

// File: tb/tb_br_predict_ctrl.sv
// Bench for br_predict_ctrl: directed scenarios plus random traffic
// against a queue-based reference of the prediction rules.
module tb_br_predict_ctrl;

  localparam int W   = 4;
  localparam int SAT = (1 << W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  br_predict_if #(.STAT_W(W)) bp ();

  br_predict_ctrl #(.STAT_W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bp  (bp)
  );

  int tests = 0;
  int fails = 0;

  typedef struct {
    bit          v;
    bit          h;
    logic [31:0] p;
  } slot_t;

  // pipe[0] is the EX slot, pipe[1] the ID slot.
  slot_t pipe[$];
  int    cnt_m[16];
  int    br_m;
  int    mis_m;

  logic [1:0]  e_flush;
  bit          e_red;
  logic [31:0] e_rpc;
  bit          e_dec;
  bit          n_we;
  int          n_idx;
  int          n_val;
  bit          s_st;
  bit          s_br;
  bit          s_h;
  logic [31:0] s_p;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    pipe.delete();
    pipe.push_back('{v: 1'b0, h: 1'b0, p: 32'd0});
    pipe.push_back('{v: 1'b0, h: 1'b0, p: 32'd0});
    foreach (cnt_m[k]) cnt_m[k] = 0;
    br_m  = 0;
    mis_m = 0;
  endtask

  task automatic cyc(input bit st, input bit h, input logic [31:0] p,
                     input logic [31:0] pc, input bit br, input bit tk,
                     input logic [31:0] tgt);
    slot_t ex;
    bp.stall      = st;
    bp.btb_hit    = h;
    bp.btb_pre_pc = p;
    bp.ex_pc      = pc;
    bp.ex_is_br   = br;
    bp.ex_taken   = tk;
    bp.ex_target  = tgt;
    #1;
    ex      = pipe[0];
    n_idx   = int'(pc[5:2]);
    e_flush = 2'b00;
    e_red   = 1'b0;
    e_rpc   = 32'd0;
    n_we    = 1'b0;
    n_val   = cnt_m[n_idx];
    e_dec   = rst && !st && ex.v;
    if (e_dec) begin
      if (br && tk) begin
        n_we = 1'b1;
        if (ex.h && ex.p == tgt) begin
          n_val = (cnt_m[n_idx] < 3) ? cnt_m[n_idx] + 1 : 3;
        end else begin
          e_red   = 1'b1;
          e_rpc   = tgt;
          e_flush = 2'b10;
          n_val   = 2;
        end
      end else if (ex.h) begin
        e_red = 1'b1;
        e_rpc = pc + 32'd4;
        n_we  = 1'b1;
        if (br && cnt_m[n_idx] >= 2) begin
          n_val = cnt_m[n_idx] - 1;
        end else begin
          e_flush = 2'b01;
          n_val   = 0;
        end
      end
    end
    chk("btb_flush", 32'(bp.btb_flush), 32'(e_flush));
    chk("redirect", 32'(bp.redirect), 32'(e_red));
    chk("redirect_pc", bp.redirect_pc, e_rpc);
    chk("upd_pc", bp.upd_pc, pc);
    chk("upd_target", bp.upd_target, tgt);
    chk("br_cnt", 32'(bp.br_cnt), 32'(br_m));
    chk("mis_cnt", 32'(bp.mis_cnt), 32'(mis_m));
    s_st = st;
    s_br = br;
    s_h  = h;
    s_p  = p;
  endtask

  task automatic tick();
    @(posedge clk);
    if (e_dec) begin
      if (n_we) cnt_m[n_idx] = n_val;
      if (s_br && br_m < SAT) br_m++;
      if (e_red && mis_m < SAT) mis_m++;
    end
    if (!s_st) begin
      void'(pipe.pop_front());
      pipe.push_back('{v: 1'b1, h: s_h, p: s_p});
      if (e_red) begin
        foreach (pipe[k]) pipe[k].v = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    int mb;
    logic [31:0] pcs [5];
    logic [31:0] tg  [3];
    pcs[0] = 32'h40; pcs[1] = 32'h44; pcs[2] = 32'h80;
    pcs[3] = 32'h7C; pcs[4] = 32'hFFFF_FFFC;
    tg[0] = 32'h100; tg[1] = 32'h200; tg[2] = 32'h0;

    rst = 1'b0;
    bp.stall = 1'b0; bp.btb_hit = 1'b0; bp.btb_pre_pc = '0;
    bp.ex_pc = '0; bp.ex_is_br = 1'b0; bp.ex_taken = 1'b0;
    bp.ex_target = '0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Fill IF/ID and ID/EX, then pull reset with a branch waiting in EX.
    cyc(0, 0, 0, 32'h0, 0, 0, 0); tick();
    cyc(0, 0, 0, 32'h0, 0, 0, 0); tick();
    bp.ex_pc = 32'h40; bp.ex_is_br = 1'b1; bp.ex_taken = 1'b1;
    bp.ex_target = 32'h100;
    #2 rst = 1'b0;
    #1;
    chk("rst_flush", 32'(bp.btb_flush), 32'd0);
    chk("rst_redirect", 32'(bp.redirect), 32'd0);
    chk("rst_rpc", bp.redirect_pc, 32'd0);
    chk("rst_br_cnt", 32'(bp.br_cnt), 32'd0);
    chk("rst_mis_cnt", 32'(bp.mis_cnt), 32'd0);
    chk("rst_upd_pc", bp.upd_pc, 32'h40);
    model_reset();
    @(negedge clk);
    rst = 1'b1;

    // Cold taken branch: decision only on the third unstalled cycle.
    cyc(0, 0, 0, 32'h40, 1, 1, 32'h100);
    chk("post_rst_no_dec0", 32'(bp.redirect), 32'd0); tick();
    cyc(0, 0, 0, 32'h40, 1, 1, 32'h100);
    chk("post_rst_no_dec1", 32'(bp.redirect), 32'd0); tick();
    cyc(0, 1, 32'h100, 32'h40, 1, 1, 32'h100);
    chk("C_flush", 32'(bp.btb_flush), 32'h2);
    chk("C_upd_pc", bp.upd_pc, 32'h40);
    chk("C_upd_tgt", bp.upd_target, 32'h100);
    chk("C_rpc", bp.redirect_pc, 32'h100);
    tick();

    // Squashed slots, then two correct predictions (cnt -> 11).
    for (int k = 0; k < 2; k++) begin
      cyc(0, 1, 32'h100, 32'h40, 1, 1, 32'h100);
      chk("squash_no_redir", 32'(bp.redirect), 32'd0); tick();
    end
    for (int k = 0; k < 2; k++) begin
      cyc(0, 1, 32'h100, 32'h40, 1, 1, 32'h100);
      chk("A_no_redir", 32'(bp.redirect), 32'd0); tick();
    end

    // Three not-taken outcomes: keep, keep, invalidate.
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 2 && r > 0; k++) begin
        cyc(0, 1, 32'h100, 32'h40, 1, 0, 32'h100); tick();
      end
      cyc(0, 1, 32'h100, 32'h40, 1, 0, 32'h100);
      chk("D_rpc", bp.redirect_pc, 32'h44);
      chk("D_flush", 32'(bp.btb_flush), (r == 2) ? 32'h1 : 32'h0);
      tick();
    end

    // Wrong target.
    cyc(0, 1, 32'h100, 32'h40, 1, 1, 32'h200); tick();
    cyc(0, 1, 32'h100, 32'h40, 1, 1, 32'h200); tick();
    cyc(0, 1, 32'h100, 32'h40, 1, 1, 32'h200);
    chk("B_flush", 32'(bp.btb_flush), 32'h2);
    chk("B_upd_tgt", bp.upd_target, 32'h200);
    chk("B_rpc", bp.redirect_pc, 32'h200);
    mb = mis_m;
    tick();
    chk("B_mis_inc", 32'(bp.mis_cnt), 32'(mb + 1));

    // Alias hit held by a 3-cycle stall.
    cyc(0, 1, 32'h100, 32'h80, 0, 0, 32'h0); tick();
    cyc(0, 1, 32'h100, 32'h80, 0, 0, 32'h0); tick();
    for (int k = 0; k < 3; k++) begin
      cyc(1, 1, 32'h100, 32'h80, 0, 0, 32'h0);
      chk("F_stall_flush", 32'(bp.btb_flush), 32'd0);
      chk("F_stall_redir", 32'(bp.redirect), 32'd0);
      tick();
    end
    cyc(0, 1, 32'h100, 32'h80, 0, 0, 32'h0);
    chk("F_flush", 32'(bp.btb_flush), 32'h1);
    chk("F_rpc", bp.redirect_pc, 32'h84);
    tick();
    cyc(0, 1, 32'h100, 32'h80, 0, 0, 32'h0);
    chk("F_one_cycle", 32'(bp.redirect), 32'd0);
    tick();

    // Random traffic, including the 0xFFFFFFFC wrap.
    for (int n = 0; n < 400; n++) begin
      cyc(($urandom_range(0, 4) == 0), 1'($urandom_range(0, 1)),
          tg[$urandom_range(0, 2)], pcs[$urandom_range(0, 4)],
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          tg[$urandom_range(0, 2)]);
      tick();
    end

    // Statistics saturation.
    rst = 1'b0;
    #1;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int n = 0; n < 60; n++) begin
      cyc(0, 0, 0, 32'h40, 1, 1, 32'h300); tick();
    end
    chk("sat_br", 32'(bp.br_cnt), 32'd15);
    chk("sat_mis", 32'(bp.mis_cnt), 32'd15);
    for (int n = 0; n < 6; n++) begin
      cyc(0, 0, 0, 32'h40, 1, 1, 32'h300); tick();
    end
    chk("sat_br_hold", 32'(bp.br_cnt), 32'd15);
    chk("sat_mis_hold", 32'(bp.mis_cnt), 32'd15);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
